// File: rtl/milano_pkg.sv
`default_nettype none
// ============================================================================
// Module   : milano_pkg
// Purpose  : Shared types and constants for the EX-stage CSR access path.
//            csr_op_e       - decoded CSR instruction flavour
//            csr_ex_state_e - occupancy state of the EX-stage CSR entry
//            CSR_RO_PREFIX  - addr[11:10] encoding of the read-only CSR space
// Revision : 1.0 - initial release
// ============================================================================
package milano_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        CSR_EX_EMPTY = 2'd0,
        CSR_EX_ISSUE = 2'd1,
        CSR_EX_HOLD  = 2'd2
    } csr_ex_state_e;

    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

endpackage : milano_pkg
`default_nettype wire

// File: rtl/csr_alu.sv
`default_nettype none
// ============================================================================
// Module   : csr_alu
// Purpose  : Combinational read-modify-write for CSRRW/CSRRS/CSRRC.
// Ports    : op_i, rdata_i, operand_i, src_zero_i, addr_i  - decoded op inputs
//            wdata_o   - value to write into the CSR
//            we_o      - op wants to write (before illegal masking)
//            illegal_o - write targets the read-only CSR space
// Revision : 1.0 - initial release
// ============================================================================
module csr_alu
    import milano_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic            src_zero_i,
    input  logic [11:0]     addr_i,
    output logic [XLEN-1:0] wdata_o,
    output logic            we_o,
    output logic            illegal_o
);

    always_comb begin
        wdata_o = rdata_i;
        we_o    = 1'b0;
        case (csr_op_e'(op_i))
            CSR_OP_RW: begin
                wdata_o = operand_i;
                we_o    = 1'b1;
            end
            // Set/clear with a zero source is a pure read: no write side effect.
            CSR_OP_RS: begin
                wdata_o = rdata_i | operand_i;
                we_o    = ~src_zero_i;
            end
            CSR_OP_RC: begin
                wdata_o = rdata_i & ~operand_i;
                we_o    = ~src_zero_i;
            end
            default: begin
                wdata_o = rdata_i;
                we_o    = 1'b0;
            end
        endcase
    end

    // Only an actual write to the read-only space is illegal; reads are fine.
    assign illegal_o = we_o & (addr_i[11:10] == CSR_RO_PREFIX);

endmodule : csr_alu
`default_nettype wire

// File: rtl/csr_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : csr_ex_stage
// Purpose  : EX-stage CSR access unit. Computes the read-modify-write value,
//            issues a single-cycle write to the CSR register file and holds
//            the old CSR value for rd writeback in a one-entry buffer.
// Ports    : clk_i, rst_i               - clock, sync active-high reset
//            id_*                       - decoded CSR op from ID (valid/ready)
//            flush_i                    - kill the issuing entry, block accept
//            ex_waddr_o/ex_wdata_o/ex_we_o - CSR register file write port
//            wb_*                       - rd writeback entry (valid/ready)
// Revision : 1.0 - initial release
// ============================================================================
module csr_ex_stage
    import milano_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [1:0]      id_csr_op_i,
    input  logic [11:0]     id_csr_addr_i,
    input  logic [XLEN-1:0] id_csr_rdata_i,
    input  logic [XLEN-1:0] id_operand_i,
    input  logic            id_src_zero_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic            flush_i,
    output logic [11:0]     ex_waddr_o,
    output logic [XLEN-1:0] ex_wdata_o,
    output logic            ex_we_o,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_rd_wdata_o,
    output logic            wb_illegal_o
);

    csr_ex_state_e   r_state;
    csr_ex_state_e   w_state_next;
    logic            w_accept;

    logic [XLEN-1:0] w_alu_wdata;
    logic            w_alu_we;
    logic            w_alu_illegal;

    logic [11:0]     r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_we;
    logic            r_illegal;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_wdata;

    csr_alu #(
        .XLEN (XLEN)
    ) u_csr_alu (
        .op_i       (id_csr_op_i),
        .rdata_i    (id_csr_rdata_i),
        .operand_i  (id_operand_i),
        .src_zero_i (id_src_zero_i),
        .addr_i     (id_csr_addr_i),
        .wdata_o    (w_alu_wdata),
        .we_o       (w_alu_we),
        .illegal_o  (w_alu_illegal)
    );

    // The entry frees up in the same cycle WB takes it, enabling back-to-back.
    assign id_ready_o = ~flush_i & ((r_state == CSR_EX_EMPTY) | wb_ready_i);
    assign w_accept   = id_valid_i & id_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= CSR_EX_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CSR_EX_EMPTY: begin
                w_state_next = w_accept ? CSR_EX_ISSUE : CSR_EX_EMPTY;
            end
            CSR_EX_ISSUE: begin
                if (flush_i) begin
                    w_state_next = CSR_EX_EMPTY;
                end else if (wb_ready_i) begin
                    w_state_next = w_accept ? CSR_EX_ISSUE : CSR_EX_EMPTY;
                end else begin
                    w_state_next = CSR_EX_HOLD;
                end
            end
            // The write already went out in ISSUE, so a flush here cannot
            // undo it; the entry simply waits for WB to retire it.
            CSR_EX_HOLD: begin
                if (wb_ready_i) begin
                    w_state_next = w_accept ? CSR_EX_ISSUE : CSR_EX_EMPTY;
                end
            end
            default: begin
                w_state_next = CSR_EX_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_illegal  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_wdata <= '0;
        end else if (w_accept) begin
            r_waddr    <= id_csr_addr_i;
            r_wdata    <= w_alu_wdata;
            r_we       <= w_alu_we;
            r_illegal  <= w_alu_illegal;
            r_rd_addr  <= id_rd_addr_i;
            // An illegal access must not leak the CSR value to rd.
            r_rd_wdata <= w_alu_illegal ? '0 : id_csr_rdata_i;
        end
    end

    assign ex_waddr_o    = r_waddr;
    assign ex_wdata_o    = r_wdata;
    assign ex_we_o       = (r_state == CSR_EX_ISSUE) & r_we & ~r_illegal & ~flush_i;
    assign wb_valid_o    = ((r_state == CSR_EX_ISSUE) & ~flush_i) | (r_state == CSR_EX_HOLD);
    assign wb_rd_addr_o  = r_rd_addr;
    assign wb_rd_wdata_o = r_rd_wdata;
    assign wb_illegal_o  = r_illegal;

endmodule : csr_ex_stage
`default_nettype wire

// File: tb/tb_csr_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_ex_stage
// Purpose  : Directed self-checking bench for csr_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_ex_stage;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            id_valid_i;
    logic            id_ready_o;
    logic [1:0]      id_csr_op_i;
    logic [11:0]     id_csr_addr_i;
    logic [XLEN-1:0] id_csr_rdata_i;
    logic [XLEN-1:0] id_operand_i;
    logic            id_src_zero_i;
    logic [4:0]      id_rd_addr_i;
    logic            flush_i;
    logic [11:0]     ex_waddr_o;
    logic [XLEN-1:0] ex_wdata_o;
    logic            ex_we_o;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [4:0]      wb_rd_addr_o;
    logic [XLEN-1:0] wb_rd_wdata_o;
    logic            wb_illegal_o;

    int checks   = 0;
    int failures = 0;

    csr_ex_stage #(
        .XLEN (XLEN)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_ready_o     (id_ready_o),
        .id_csr_op_i    (id_csr_op_i),
        .id_csr_addr_i  (id_csr_addr_i),
        .id_csr_rdata_i (id_csr_rdata_i),
        .id_operand_i   (id_operand_i),
        .id_src_zero_i  (id_src_zero_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .flush_i        (flush_i),
        .ex_waddr_o     (ex_waddr_o),
        .ex_wdata_o     (ex_wdata_o),
        .ex_we_o        (ex_we_o),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_rd_addr_o   (wb_rd_addr_o),
        .wb_rd_wdata_o  (wb_rd_wdata_o),
        .wb_illegal_o   (wb_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change 1ns after the edge, outputs are
    // sampled a few ns later, well away from the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_op(input logic v, input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] rdata, input logic [31:0] operand,
                            input logic sz, input logic [4:0] rd);
        id_valid_i     = v;
        id_csr_op_i    = op;
        id_csr_addr_i  = addr;
        id_csr_rdata_i = rdata;
        id_operand_i   = operand;
        id_src_zero_i  = sz;
        id_rd_addr_i   = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b1;
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        step(); step();
        rst_i = 1'b0;
        settle();
        checks++;
        if (id_ready_o !== 1'b1) begin failures++; $display("FAIL reset_id_ready got=%b exp=1", id_ready_o); end
        checks++;
        if (ex_we_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_strobes got we=%b valid=%b exp=0/0", ex_we_o, wb_valid_o);
        end
        checks++;
        if (ex_waddr_o !== 12'h0 || ex_wdata_o !== 32'h0 || wb_rd_wdata_o !== 32'h0 ||
            wb_rd_addr_o !== 5'd0 || wb_illegal_o !== 1'b0) begin
            failures++; $display("FAIL reset_data got waddr=%h wdata=%h rdw=%h rd=%0d ill=%b exp=all 0",
                                 ex_waddr_o, ex_wdata_o, wb_rd_wdata_o, wb_rd_addr_o, wb_illegal_o);
        end
    endtask

    task automatic test_rw();
        drive_op(1'b1, 2'd1, 12'h340, 32'h0, 32'hDEADBEEF, 1'b0, 5'd7);
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        settle();
        checks++;
        if (ex_we_o !== 1'b1 || ex_waddr_o !== 12'h340 || ex_wdata_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rw_write got we=%b addr=%h data=%h exp=1/340/deadbeef",
                                 ex_we_o, ex_waddr_o, ex_wdata_o);
        end
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_wdata_o !== 32'h0 || wb_illegal_o !== 1'b0 || wb_rd_addr_o !== 5'd7) begin
            failures++; $display("FAIL rw_wb got valid=%b rdw=%h ill=%b rd=%0d exp=1/0/0/7",
                                 wb_valid_o, wb_rd_wdata_o, wb_illegal_o, wb_rd_addr_o);
        end
        step();
        settle();
        checks++;
        if (ex_we_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            failures++; $display("FAIL rw_retire got we=%b valid=%b exp=0/0", ex_we_o, wb_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b1, 2'd2, 12'h300, 32'h00000008, 32'h80, 1'b0, 5'd3);
        step();
        // RC's rdata is the value forwarded from RS's write this cycle.
        drive_op(1'b1, 2'd3, 12'h300, 32'h88, 32'h08, 1'b0, 5'd4);
        settle();
        checks++;
        if (ex_we_o !== 1'b1 || ex_wdata_o !== 32'h88 || id_ready_o !== 1'b1) begin
            failures++; $display("FAIL b2b_rs got we=%b data=%h rdy=%b exp=1/88/1", ex_we_o, ex_wdata_o, id_ready_o);
        end
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        settle();
        checks++;
        if (ex_we_o !== 1'b1 || ex_wdata_o !== 32'h80 || wb_rd_wdata_o !== 32'h88 || wb_rd_addr_o !== 5'd4) begin
            failures++; $display("FAIL b2b_rc got we=%b data=%h rdw=%h rd=%0d exp=1/80/88/4",
                                 ex_we_o, ex_wdata_o, wb_rd_wdata_o, wb_rd_addr_o);
        end
        step();
    endtask

    task automatic test_ro_read();
        drive_op(1'b1, 2'd2, 12'hF14, 32'h00001234, 32'h0, 1'b1, 5'd5);
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        settle();
        checks++;
        if (ex_we_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_illegal_o !== 1'b0 || wb_rd_wdata_o !== 32'h1234) begin
            failures++; $display("FAIL ro_read got we=%b valid=%b ill=%b rdw=%h exp=0/1/0/1234",
                                 ex_we_o, wb_valid_o, wb_illegal_o, wb_rd_wdata_o);
        end
        step();
    endtask

    task automatic test_illegal();
        drive_op(1'b1, 2'd1, 12'hF11, 32'h00005555, 32'h1, 1'b0, 5'd6);
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        settle();
        checks++;
        if (ex_we_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_illegal_o !== 1'b1 || wb_rd_wdata_o !== 32'h0) begin
            failures++; $display("FAIL illegal got we=%b valid=%b ill=%b rdw=%h exp=0/1/1/0",
                                 ex_we_o, wb_valid_o, wb_illegal_o, wb_rd_wdata_o);
        end
        step();
    endtask

    task automatic test_hold();
        int we_cnt    = 0;
        int valid_cnt = 0;
        wb_ready_i = 1'b0;
        drive_op(1'b1, 2'd1, 12'h341, 32'h0, 32'hA5, 1'b0, 5'd9);
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            wb_ready_i = (i == 3);
            settle();
            if (ex_we_o === 1'b1) we_cnt++;
            if (wb_valid_o === 1'b1) valid_cnt++;
            if (i == 1 || i == 2) begin
                checks++;
                if (id_ready_o !== 1'b0) begin
                    failures++; $display("FAIL hold_id_ready cycle=%0d got=%b exp=0", i, id_ready_o);
                end
            end
            step();
        end
        settle();
        if (ex_we_o === 1'b1) we_cnt++;
        checks++;
        if (we_cnt != 1) begin failures++; $display("FAIL hold_we_pulses got=%0d exp=1", we_cnt); end
        checks++;
        if (valid_cnt != 4) begin failures++; $display("FAIL hold_valid_cycles got=%0d exp=4", valid_cnt); end
        checks++;
        if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL hold_retire got valid=%b exp=0", wb_valid_o); end
        wb_ready_i = 1'b1;
    endtask

    task automatic test_flush();
        drive_op(1'b1, 2'd1, 12'h342, 32'h0, 32'h77, 1'b0, 5'd10);
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        flush_i = 1'b1;
        settle();
        checks++;
        if (ex_we_o !== 1'b0 || wb_valid_o !== 1'b0 || id_ready_o !== 1'b0) begin
            failures++; $display("FAIL flush_issue got we=%b valid=%b rdy=%b exp=0/0/0", ex_we_o, wb_valid_o, id_ready_o);
        end
        // Keep flush up with a pending ID op: it must not be accepted.
        drive_op(1'b1, 2'd1, 12'h343, 32'h0, 32'h99, 1'b0, 5'd11);
        step();
        settle();
        checks++;
        if (wb_valid_o !== 1'b0 || ex_we_o !== 1'b0) begin
            failures++; $display("FAIL flush_state got valid=%b we=%b exp=0/0", wb_valid_o, ex_we_o);
        end
        flush_i = 1'b0;
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        settle();
        checks++;
        if (ex_we_o !== 1'b1 || ex_waddr_o !== 12'h343 || ex_wdata_o !== 32'h99) begin
            failures++; $display("FAIL flush_pending got we=%b addr=%h data=%h exp=1/343/99",
                                 ex_we_o, ex_waddr_o, ex_wdata_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_op(1'b1, 2'd1, 12'h344, 32'h12, 32'hCAFE, 1'b0, 5'd12);
        step();
        drive_op(1'b0, 2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        rst_i = 1'b1;
        step();
        settle();
        checks++;
        if (ex_we_o !== 1'b0 || wb_valid_o !== 1'b0 || ex_waddr_o !== 12'h0 ||
            ex_wdata_o !== 32'h0 || wb_rd_wdata_o !== 32'h0 || wb_rd_addr_o !== 5'd0) begin
            failures++; $display("FAIL reset_mid got we=%b valid=%b addr=%h data=%h rdw=%h rd=%0d exp=all 0",
                                 ex_we_o, wb_valid_o, ex_waddr_o, ex_wdata_o, wb_rd_wdata_o, wb_rd_addr_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rw();
        test_back_to_back();
        test_ro_read();
        test_illegal();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_csr_ex_stage
`default_nettype wire
